// File: rtl/br_redirect_if.sv
// Bundle between the EXE branch back end and its neighbours: EXE issue, fetch redirect,
// trap unit and perf counters. The slave side is the br_redirect block.
interface br_redirect_if #(
  parameter int unsigned PC_SZ  = 32,
  parameter int unsigned CNT_SZ = 32
);
  logic              exe_valid_in;
  logic              exe_ready_out;
  logic              exe_is_br_in;
  logic [PC_SZ-1:0]  exe_pc_in;
  logic [PC_SZ-1:0]  exe_pred_pc_in;
  logic [PC_SZ-1:0]  br_pc_in;
  logic              mis_in;
  logic              redir_valid_out;
  logic              redir_ready_in;
  logic [PC_SZ-1:0]  redir_pc_out;
  logic              flush_out;
  logic              exc_valid_out;
  logic              exc_ack_in;
  logic [PC_SZ-1:0]  exc_pc_out;
  logic [PC_SZ-1:0]  exc_tval_out;
  logic [CNT_SZ-1:0] br_cnt_out;
  logic [CNT_SZ-1:0] mispred_cnt_out;

  // Environment side: EXE stage, fetch, trap unit.
  modport master (
    output exe_valid_in, exe_is_br_in, exe_pc_in, exe_pred_pc_in, br_pc_in, mis_in,
    output redir_ready_in, exc_ack_in,
    input  exe_ready_out, redir_valid_out, redir_pc_out, flush_out,
    input  exc_valid_out, exc_pc_out, exc_tval_out, br_cnt_out, mispred_cnt_out
  );

  // Block side.
  modport slave (
    input  exe_valid_in, exe_is_br_in, exe_pc_in, exe_pred_pc_in, br_pc_in, mis_in,
    input  redir_ready_in, exc_ack_in,
    output exe_ready_out, redir_valid_out, redir_pc_out, flush_out,
    output exc_valid_out, exc_pc_out, exc_tval_out, br_cnt_out, mispred_cnt_out
  );
endinterface

// File: rtl/br_redirect.sv
// EXE-stage branch back end: compares the resolved next PC with the one fetch used, raises a
// redirect (or a misaligned-target exception) with a one-cycle flush, and counts control
// transfers and mispredicts.
module br_redirect #(
  parameter int unsigned PC_SZ  = 32,
  parameter int unsigned CNT_SZ = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  br_redirect_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRedir, StExc} state_e;

  state_e            state_q;
  logic              redir_valid_q;
  logic              flush_q;
  logic              exc_valid_q;
  logic [PC_SZ-1:0]  redir_pc_q;
  logic [PC_SZ-1:0]  exc_pc_q;
  logic [PC_SZ-1:0]  exc_tval_q;
  logic [CNT_SZ-1:0] br_cnt_q;
  logic [CNT_SZ-1:0] mispred_cnt_q;
  logic              accept_br;

  // A control transfer is only taken while idle; ready depends on state alone.
  assign bus.exe_ready_out = (state_q == StIdle);
  assign accept_br         = bus.exe_valid_in & bus.exe_is_br_in;

  // FSM with registered outputs; flush defaults low so it pulses once per event.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= StIdle;
      redir_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      exc_valid_q   <= 1'b0;
      redir_pc_q    <= '0;
      exc_pc_q      <= '0;
      exc_tval_q    <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept_br) begin
            br_cnt_q <= br_cnt_q + 1'b1;
            if (bus.mis_in) begin
              // Misaligned target traps; the trap unit steers fetch, not us.
              state_q     <= StExc;
              exc_valid_q <= 1'b1;
              exc_pc_q    <= bus.exe_pc_in;
              exc_tval_q  <= bus.br_pc_in;
              flush_q     <= 1'b1;
            end else if (bus.br_pc_in != bus.exe_pred_pc_in) begin
              state_q       <= StRedir;
              redir_valid_q <= 1'b1;
              redir_pc_q    <= bus.br_pc_in;
              mispred_cnt_q <= mispred_cnt_q + 1'b1;
              flush_q       <= 1'b1;
            end
          end
        end
        StRedir: begin
          if (bus.redir_ready_in) begin
            state_q       <= StIdle;
            redir_valid_q <= 1'b0;
          end
        end
        StExc: begin
          if (bus.exc_ack_in) begin
            state_q     <= StIdle;
            exc_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= StIdle;
          redir_valid_q <= 1'b0;
          exc_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redir_valid_out = redir_valid_q;
  assign bus.redir_pc_out    = redir_pc_q;
  assign bus.flush_out       = flush_q;
  assign bus.exc_valid_out   = exc_valid_q;
  assign bus.exc_pc_out      = exc_pc_q;
  assign bus.exc_tval_out    = exc_tval_q;
  assign bus.br_cnt_out      = br_cnt_q;
  assign bus.mispred_cnt_out = mispred_cnt_q;

endmodule
